// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte (e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable) to the
// keyboard. The bus is driven open-drain: an *_oe output of 1 pulls the line
// low, 0 releases it; the top level builds the actual tristates.
//
// Sequence: inhibit (clock held low), request-to-send (data low, clock
// released), then the device clocks out 8 data bits LSB first, odd parity and
// a released stop bit, and finally ACKs by pulling data low on falling edge 11.
//
// Optional build macro: PS2_HOST_TX_TIMEOUT_EN
//   defined   -> START_TIMEOUT / XFER_TIMEOUT counters are built; expiry fails
//                the transfer.
//   undefined -> no timeout counters; the protocol states wait indefinitely and
//                only a missing ACK can fail a transfer.
//
// Ports:
//   clock       system clock (50 MHz)
//   reset       synchronous, active-low reset
//   send        start request, sampled only while idle
//   cmd_data    command byte, latched on an accepted send
//   ps2_clk_in  raw PS2_CLK pin level
//   ps2_dat_in  raw PS2_DAT pin level
//   ps2_clk_oe  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  1 = pull PS2_DAT low, 0 = release
//   busy        high from accepted send until done
//   done        one-cycle pulse at the end of every transfer, pass or fail
//   error       level, set with done on a failed transfer, cleared on next send
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    // Odd parity: the parity bit makes the total number of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    state_t           state_r;
    logic [1:0]       clk_sync_r;
    logic [1:0]       dat_sync_r;
    logic             clk_prev_r;
    logic [8:0]       shift_r;      // {parity, data}, shifted right as bits go out
    logic [3:0]       bit_cnt_r;
    logic [INH_W-1:0] inh_cnt_r;
    logic             clk_s;
    logic             dat_s;
    logic             fall_s;
    logic             start_exp_s;
    logic             xfer_exp_s;

    assign clk_s  = clk_sync_r[1];
    assign dat_s  = dat_sync_r[1];
    assign fall_s = clk_prev_r & ~clk_sync_r[1];

    // Two-flop synchronizers on both pins plus the previous clock sample for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
            dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
            clk_prev_r <= clk_sync_r[1];
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int               TMO_MAX    = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int               TMO_W      = $clog2(TMO_MAX + 1);
    localparam logic [TMO_W-1:0] START_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] XFER_LAST  = TMO_W'(XFER_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Shared timeout counter: runs from clock release in REQ, restarts on the
    // first falling edge and then covers the whole DATA/ACK/WAIT_IDLE span.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_REQ) begin
            tmo_cnt_r <= fall_s ? '0 : (tmo_cnt_r + TMO_ONE);
        end else if ((state_r == ST_DATA) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign start_exp_s = (tmo_cnt_r == START_LAST);
    assign xfer_exp_s  = (tmo_cnt_r == XFER_LAST);
`else
    // No timeout hardware: these terms are constant 0 for any positive timeout.
    assign start_exp_s = (START_TIMEOUT < 32'sd0);
    assign xfer_exp_s  = (XFER_TIMEOUT < 32'sd0);
`endif

    // Transfer FSM; all bus enables and status outputs are registered here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            shift_r    <= 9'd0;
            bit_cnt_r  <= 4'd0;
            inh_cnt_r  <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    // A send coinciding with the done pulse is deliberately ignored.
                    if (send && !done) begin
                        shift_r    <= {odd_parity(cmd_data), cmd_data};
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        inh_cnt_r  <= '0;
                        ps2_clk_oe <= 1'b1;
                        state_r    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_r == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b1;     // start bit
                        state_r    <= ST_REQ;
                    end else begin
                        inh_cnt_r <= inh_cnt_r + INH_ONE;
                    end
                end
                ST_REQ: begin
                    if (start_exp_s) begin
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_FAIL;
                    end else if (fall_s) begin
                        // First falling edge presents bit 0; ones shifted in act as the stop bit.
                        ps2_dat_oe <= ~shift_r[0];
                        shift_r    <= {1'b1, shift_r[8:1]};
                        bit_cnt_r  <= 4'd0;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer_exp_s) begin
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_FAIL;
                    end else if (fall_s) begin
                        // bit_cnt_r == 8 marks falling edge 10: release data as the stop bit.
                        if (bit_cnt_r == 4'd8) begin
                            ps2_dat_oe <= 1'b0;
                            state_r    <= ST_ACK;
                        end else begin
                            ps2_dat_oe <= ~shift_r[0];
                            shift_r    <= {1'b1, shift_r[8:1]};
                        end
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                end
                ST_ACK: begin
                    if (xfer_exp_s) begin
                        state_r <= ST_FAIL;
                    end else if (fall_s) begin
                        state_r <= dat_s ? ST_FAIL : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (xfer_exp_s) begin
                        state_r <= ST_FAIL;
                    end else if (clk_s && dat_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    done       <= 1'b1;
                    error      <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: directed steps against an open-drain PS/2 device
// model. The device clocks at a faster bit rate than a real keyboard so the
// whole sequence stays short; the 5000-cycle inhibit is kept at full length.
module tb_ps2_host_tx;

    localparam int HALF     = 20;      // device clock half period, system cycles
    localparam int TB_START = 300;
    localparam int TB_XFER  = 3000;

    logic       clock;
    logic       reset;
    logic       send;
    logic [7:0] cmd_data;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       dev_clk;
    logic       dev_dat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int   done_cnt      = 0;
    int   done_cyc      = 0;
    int   busy_cycles   = 0;
    int   busy_rise_cyc = 0;
    int   clk_run       = 0;
    int   last_run      = 0;
    int   rel_cyc       = 0;
    logic err_at_done   = 1'b0;
    logic busy_at_done  = 1'b0;
    logic busy_prev     = 1'b0;

    // Wired-AND bus: a line is low if either side pulls it.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .START_TIMEOUT (TB_START),
        .XFER_TIMEOUT  (TB_XFER)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .cmd_data  (cmd_data),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observers sampled on the falling system clock edge.
    always @(negedge clock) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            err_at_done  <= error;
            busy_at_done <= busy;
        end
        if (busy) busy_cycles <= busy_cycles + 1;
        if (busy && !busy_prev) busy_rise_cyc <= cyc;
        busy_prev <= busy;
        if (ps2_clk_oe) begin
            clk_run <= clk_run + 1;
        end else if (clk_run != 0) begin
            last_run <= clk_run;
            rel_cyc  <= cyc;
            clk_run  <= 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send     = 1'b1;
        cmd_data = b;
        tick();
        send = 1'b0;
    endtask

    // Device side: wait for request-to-send, clock n_edges falling edges,
    // sample data before each rising edge, optionally ACK on edge 11.
    task automatic device_xfer(input int n_edges, input bit ack, output logic [9:0] bits, output bit seen_req);
        seen_req = 1'b0;
        bits     = 10'h3FF;
        for (int w = 0; w < 20000 && !seen_req; w++) begin
            tick();
            if (ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) seen_req = 1'b1;
        end
        if (seen_req) begin
            for (int i = 0; i < n_edges && i < 10; i++) begin
                repeat (HALF) tick();
                dev_clk = 1'b0;
                repeat (HALF) tick();
                bits[i] = ps2_dat_in;
                dev_clk = 1'b1;
            end
            if (n_edges == 11) begin
                if (ack) dev_dat = 1'b0;
                repeat (HALF) tick();
                dev_clk = 1'b0;
                repeat (HALF) tick();
                dev_clk = 1'b1;
                dev_dat = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int d0);
        bit got;
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            tick();
            if (done_cnt != d0) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        repeat (5) tick();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] b, input bit ack,
                             input logic [7:0] exp_byte, input logic exp_par, input logic exp_err);
        logic [9:0] bits;
        bit         seen;
        int         d0;
        d0 = done_cnt;
        send_cmd(b);
        check({tag, "_busy_acc"}, 32'(busy), 32'd1);
        device_xfer(11, ack, bits, seen);
        check({tag, "_req_seen"}, 32'(seen), 32'd1);
        check({tag, "_byte"}, 32'(bits[7:0]), 32'(exp_byte));
        check({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
        check({tag, "_stop"}, 32'(bits[9]), 32'd1);
        wait_done(tag, d0);
        check({tag, "_error"}, 32'(err_at_done), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        bit         seen;
        int         d0;
        int         bc0;
        bit         got;

        reset    = 1'b0;
        send     = 1'b0;
        cmd_data = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        repeat (5) tick();

        // 1: reset mid-DATA after four falling edges releases the bus, no done
        d0 = done_cnt;
        send_cmd(8'h55);
        device_xfer(4, 1'b1, bits, seen);
        check("t1_req_seen", 32'(seen), 32'd1);
        check("t1_bits_0_3", 32'(bits[3:0]), 32'h5);
        reset = 1'b0;
        tick();
        check("t1_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t1_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (50) tick();
        check("t1_no_done", 32'(done_cnt - d0), 32'd0);
        full_xfer("t1_f4", 8'hF4, 1'b1, 8'hF4, 1'b0, 1'b0);
        repeat (20) tick();

        // 2: 0xED, parity 1, inhibit exactly 5000 cycles
        full_xfer("t2_ed", 8'hED, 1'b1, 8'hED, 1'b1, 1'b0);
        check("t2_inhibit_len", 32'(last_run), 32'd5000);
        repeat (20) tick();

        // 3: 0xF4, parity 0, busy spans accept+1 up to the done cycle
        bc0 = busy_cycles;
        full_xfer("t3_f4", 8'hF4, 1'b1, 8'hF4, 1'b0, 1'b0);
        check("t3_busy_span", 32'(busy_cycles - bc0), 32'(done_cyc - busy_rise_cyc));
        repeat (20) tick();

        // 4: 0xFF with no ACK fails
        full_xfer("t4_ff", 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1);
        check("t4_error_lvl", 32'(error), 32'd1);
        check("t4_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t4_dat_oe", 32'(ps2_dat_oe), 32'd0);
        repeat (20) tick();

        // 6: send held high across two transfers; cmd_data changes after latch
        d0       = done_cnt;
        send     = 1'b1;
        cmd_data = 8'h12;
        tick();
        check("t6_busy_acc", 32'(busy), 32'd1);
        check("t6_error_clr", 32'(error), 32'd0);
        cmd_data = 8'hAA;
        device_xfer(11, 1'b1, bits, seen);
        check("t6a_req_seen", 32'(seen), 32'd1);
        check("t6a_byte", 32'(bits[7:0]), 32'h12);
        check("t6a_parity", 32'(bits[8]), 32'd1);
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            tick();
            if (done_cnt != d0 && busy_rise_cyc > done_cyc) got = 1'b1;
        end
        check("t6_restart_seen", 32'(got), 32'd1);
        check("t6_restart_gap", 32'(busy_rise_cyc - done_cyc), 32'd2);
        check("t6a_error", 32'(err_at_done), 32'd0);
        send = 1'b0;
        d0   = done_cnt;
        device_xfer(11, 1'b1, bits, seen);
        check("t6b_req_seen", 32'(seen), 32'd1);
        check("t6b_byte", 32'(bits[7:0]), 32'hAA);
        check("t6b_parity", 32'(bits[8]), 32'd1);
        wait_done("t6b", d0);
        check("t6b_error", 32'(err_at_done), 32'd0);
        repeat (20) tick();

        // 5: 0x00 and the device never clocks
        d0 = done_cnt;
        send_cmd(8'h00);
        got = 1'b0;
        for (int w = 0; w < 6000 && !got; w++) begin
            tick();
            if (ps2_clk_oe === 1'b0) got = 1'b1;
        end
        check("t5_released", 32'(got), 32'd1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wait_done("t5", d0);
        // FAIL state sits TB_START cycles after release; done follows one cycle later.
        check("t5_timeout_lat", 32'(done_cyc - rel_cyc), 32'(TB_START + 1));
        check("t5_error", 32'(err_at_done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
`else
        repeat (2000) tick();
        check("t5_busy_held", 32'(busy), 32'd1);
        check("t5_dat_oe_held", 32'(ps2_dat_oe), 32'd1);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_busy_rst", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
